// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ann_pkg
// Description : Shared types and defaults for the multi-layer ANN sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ann_pkg;

    // Default network limits
    localparam int c_max_layers  = 4;
    localparam int c_max_inputs  = 784;
    localparam int c_max_neurons = 64;
    localparam int c_addr_w      = 16;

    // Widths of the index/count buses for the default limits
    localparam int c_layer_w = $clog2(c_max_layers + 1);
    localparam int c_in_w    = $clog2(c_max_inputs + 1);
    localparam int c_neu_w   = $clog2(c_max_neurons + 1);

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_LAYER = 3'd1,
        S_REQ        = 3'd2,
        S_STORE      = 3'd3,
        S_LAYER_END  = 3'd4,
        S_DONE       = 3'd5,
        S_ERR        = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ann_flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : ann_flex_counter
// Description : Up-counter with synchronous clear, count enable and a
//               run-time rollover value. The rollover flag is high whenever
//               the count sits on the rollover value, so the next enabled
//               count returns to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ann_flex_counter
    import ann_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_count_en,
    input  logic [WIDTH-1:0] i_rollover_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_rollover_flag
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear dominates enable; wrap to zero at the rollover value
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            if (r_count == i_rollover_val) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count         = r_count;
    assign o_rollover_flag = (r_count == i_rollover_val);

endmodule
`default_nettype wire

// File: rtl/ann_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : ann_seq_controller
// Description : Sequences a fully-connected network of up to MAX_LAYERS
//               layers over one shared MAC. Per neuron it fetches every
//               coefficient, strobes the MAC per ack, stores the activated
//               result and swaps activation buffers between layers. Layer
//               sizes come from an external combinational size ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module ann_seq_controller
    import ann_pkg::*;
#(
    parameter int MAX_LAYERS  = c_max_layers,
    parameter int MAX_INPUTS  = c_max_inputs,
    parameter int MAX_NEURONS = c_max_neurons,
    parameter int ADDR_W      = c_addr_w,
    parameter int LAYER_W     = $clog2(MAX_LAYERS + 1),
    parameter int IN_W        = $clog2(MAX_INPUTS + 1),
    parameter int NEU_W       = $clog2(MAX_NEURONS + 1)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               image_loaded,
    input  logic               start,
    input  logic               abort,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [IN_W-1:0]    layer_in_cnt,
    input  logic [NEU_W-1:0]   layer_out_cnt,
    input  logic               coeff_valid,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [NEU_W-1:0]   neuron_idx,
    output logic [IN_W-1:0]    input_idx,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic               request,
    output logic               mac_en,
    output logic               acc_clear,
    output logic               store_out,
    output logic               swap_buf,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [IN_W-1:0]  c_in_max  = IN_W'(MAX_INPUTS);
    localparam logic [NEU_W-1:0] c_neu_max = NEU_W'(MAX_NEURONS);

    state_t               r_state;
    state_t               w_next_state;
    logic [LAYER_W-1:0]   r_num_layers;
    logic [IN_W-1:0]      r_in_cnt;
    logic [NEU_W-1:0]     r_out_cnt;
    logic [ADDR_W-1:0]    r_coeff_addr;

    logic w_accept;
    logic w_ack;
    logic w_clear_idx;
    logic w_cfg_bad;
    logic w_in_last;
    logic w_neu_last;
    logic w_layer_last;
    logic w_layer_step;

    // A start is taken only from IDLE with a full image buffer
    assign w_accept     = (r_state == S_IDLE) && start && image_loaded;
    // One coefficient consumed: only meaningful while requesting
    assign w_ack        = (r_state == S_REQ) && coeff_valid;
    // Indices restart on a new inference and on abort
    assign w_clear_idx  = w_accept || abort;
    // Layer index moves on only when another layer follows
    assign w_layer_step = (r_state == S_LAYER_END) && !w_layer_last;

    // Configuration check uses the live ROM values seen during LOAD_LAYER
    assign w_cfg_bad = (r_num_layers == '0)
                    || (layer_in_cnt == '0)
                    || (layer_out_cnt == '0)
                    || (layer_in_cnt > c_in_max)
                    || (layer_out_cnt > c_neu_max);

    ann_flex_counter #(.WIDTH(IN_W)) u_input_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_clear         (w_clear_idx),
        .i_count_en      (w_ack),
        .i_rollover_val  (r_in_cnt - IN_W'(1)),
        .o_count         (input_idx),
        .o_rollover_flag (w_in_last)
    );

    ann_flex_counter #(.WIDTH(NEU_W)) u_neuron_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_clear         (w_clear_idx),
        .i_count_en      (r_state == S_STORE),
        .i_rollover_val  (r_out_cnt - NEU_W'(1)),
        .o_count         (neuron_idx),
        .o_rollover_flag (w_neu_last)
    );

    ann_flex_counter #(.WIDTH(LAYER_W)) u_layer_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_clear         (w_clear_idx),
        .i_count_en      (w_layer_step),
        .i_rollover_val  (r_num_layers - LAYER_W'(1)),
        .o_count         (layer_idx),
        .o_rollover_flag (w_layer_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Layer count is captured at start and survives abort
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_num_layers <= '0;
        end else if (w_accept && !abort) begin
            r_num_layers <= num_layers;
        end
    end

    // Capture this layer's sizes from the size ROM during LOAD_LAYER
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (r_state == S_LOAD_LAYER) begin
            r_in_cnt  <= layer_in_cnt;
            r_out_cnt <= layer_out_cnt;
        end
    end

    // Linear coefficient address advances once per ack and wraps naturally
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_coeff_addr <= '0;
        end else if (w_clear_idx) begin
            r_coeff_addr <= '0;
        end else if (w_ack) begin
            r_coeff_addr <= r_coeff_addr + ADDR_W'(1);
        end
    end

    assign coeff_addr = r_coeff_addr;

    // Next-state selection; abort overrides every other transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && image_loaded) begin
                    w_next_state = S_LOAD_LAYER;
                end
            end
            S_LOAD_LAYER: begin
                w_next_state = w_cfg_bad ? S_ERR : S_REQ;
            end
            S_REQ: begin
                if (coeff_valid && w_in_last) begin
                    w_next_state = S_STORE;
                end
            end
            S_STORE: begin
                w_next_state = w_neu_last ? S_LAYER_END : S_REQ;
            end
            S_LAYER_END: begin
                w_next_state = w_layer_last ? S_DONE : S_LOAD_LAYER;
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Strobes decoded from the current state; mac_en follows the ack directly
    always_comb begin
        request   = 1'b0;
        mac_en    = 1'b0;
        acc_clear = 1'b0;
        store_out = 1'b0;
        swap_buf  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_LOAD_LAYER: acc_clear = 1'b1;
            S_REQ: begin
                request = 1'b1;
                mac_en  = coeff_valid;
            end
            S_STORE: begin
                store_out = 1'b1;
                acc_clear = 1'b1;
            end
            S_LAYER_END: swap_buf = 1'b1;
            S_DONE:      done     = 1'b1;
            S_ERR:       error    = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ann_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ann_seq_controller
// Description : Self-checking bench for ann_seq_controller. Each inference is
//               expanded into an expected per-cycle trace by nested loops over
//               layers, neurons and inputs; a compare process checks every
//               output on every cycle against that trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ann_seq_controller;
    import ann_pkg::*;

    localparam int LW = c_layer_w;
    localparam int IW = c_in_w;
    localparam int NW = c_neu_w;
    localparam int AW = c_addr_w;
    localparam int MI = c_max_inputs;
    localparam int MN = c_max_neurons;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          image_loaded;
    logic          start;
    logic          abort;
    logic [LW-1:0] num_layers;
    logic [IW-1:0] layer_in_cnt;
    logic [NW-1:0] layer_out_cnt;
    logic          coeff_valid;
    logic [LW-1:0] layer_idx;
    logic [NW-1:0] neuron_idx;
    logic [IW-1:0] input_idx;
    logic [AW-1:0] coeff_addr;
    logic          request, mac_en, acc_clear, store_out, swap_buf;
    logic          busy, done, error;

    always #5 clk = ~clk;

    // Size ROM seen by the DUT, indexed by its current layer
    int rom_in  [8];
    int rom_out [8];
    assign layer_in_cnt  = rom_in[layer_idx][IW-1:0];
    assign layer_out_cnt = rom_out[layer_idx][NW-1:0];

    ann_seq_controller dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .image_loaded  (image_loaded),
        .start         (start),
        .abort         (abort),
        .num_layers    (num_layers),
        .layer_in_cnt  (layer_in_cnt),
        .layer_out_cnt (layer_out_cnt),
        .coeff_valid   (coeff_valid),
        .layer_idx     (layer_idx),
        .neuron_idx    (neuron_idx),
        .input_idx     (input_idx),
        .coeff_addr    (coeff_addr),
        .request       (request),
        .mac_en        (mac_en),
        .acc_clear     (acc_clear),
        .store_out     (store_out),
        .swap_buf      (swap_buf),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // One cycle of stimulus plus the outputs that cycle must show
    typedef struct {
        logic          start, il, cv, ab;
        logic [LW-1:0] nl;
        logic          busy, request, mac_en, acc_clear, store_out, swap_buf, done, error;
        int            lay, neu, inp, addr;
    } cyc_t;

    cyc_t tr[$];
    cyc_t exp_c;
    bit   chk_en = 1'b0;
    int   cyc_i  = -1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   idle_l = 0;
    int   idle_addr = 0;
    int   m_done = 0;

    // Observed DUT activity, written only by the compare process
    int mac_cnt = 0, store_cnt = 0, swap_cnt = 0, done_cnt = 0, req_cnt = 0;
    int done_at = -1, error_at = -1, addr_at_done = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s (run cycle %0d): got %0d, expected %0d", nm, cyc_i, act, expv);
        end
    endtask

    // Compare every output against the trace on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc_i == 0) begin
                done_at  = -1;
                error_at = -1;
            end
            chk("busy",       32'(busy),       32'(exp_c.busy));
            chk("request",    32'(request),    32'(exp_c.request));
            chk("mac_en",     32'(mac_en),     32'(exp_c.mac_en));
            chk("acc_clear",  32'(acc_clear),  32'(exp_c.acc_clear));
            chk("store_out",  32'(store_out),  32'(exp_c.store_out));
            chk("swap_buf",   32'(swap_buf),   32'(exp_c.swap_buf));
            chk("done",       32'(done),       32'(exp_c.done));
            chk("error",      32'(error),      32'(exp_c.error));
            chk("layer_idx",  32'(layer_idx),  32'(exp_c.lay));
            chk("neuron_idx", 32'(neuron_idx), 32'(exp_c.neu));
            chk("input_idx",  32'(input_idx),  32'(exp_c.inp));
            chk("coeff_addr", 32'(coeff_addr), 32'(exp_c.addr));
            mac_cnt   += int'(mac_en);
            store_cnt += int'(store_out);
            swap_cnt  += int'(swap_buf);
            done_cnt  += int'(done);
            req_cnt   += int'(request);
            if (done) begin
                done_at      = cyc_i;
                addr_at_done = int'(coeff_addr);
            end
            if (error) error_at = cyc_i;
        end
    end

    // Cycle with random don't-care stimulus; in IDLE start never pairs with image_loaded
    function automatic cyc_t mk(input bit bsy, input int l, input int n, input int i, input int a);
        cyc_t c;
        c.start = 1'($urandom_range(0, 1));
        c.il    = bsy ? 1'($urandom_range(0, 1)) : 1'b0;
        c.cv    = 1'($urandom_range(0, 1));
        c.ab    = 1'b0;
        c.nl    = LW'($urandom_range(0, 7));
        c.busy = bsy; c.request = 0; c.mac_en = 0; c.acc_clear = 0;
        c.store_out = 0; c.swap_buf = 0; c.done = 0; c.error = 0;
        c.lay = l; c.neu = n; c.inp = i; c.addr = a;
        return c;
    endfunction

    // Expand one inference into its expected trace (T0 = start cycle at index 0)
    task automatic build_run(input int nl, input int wmin, input int wmax, input int abort_at);
        cyc_t c;
        int   a;
        int   w;
        c = mk(0, idle_l, 0, 0, idle_addr);
        c.start = 1'b1; c.il = 1'b1; c.nl = LW'(nl);
        tr.push_back(c);
        a = 0;
        for (int l = 0; l < 8; l++) begin
            c = mk(1, l, 0, 0, a); c.acc_clear = 1'b1; tr.push_back(c);
            if (nl == 0 || rom_in[l] < 1 || rom_out[l] < 1 || rom_in[l] > MI || rom_out[l] > MN) begin
                c = mk(1, l, 0, 0, a); c.error = 1'b1; tr.push_back(c);
                idle_l = l; idle_addr = a;
                break;
            end
            for (int n = 0; n < rom_out[l]; n++) begin
                for (int i = 0; i < rom_in[l]; i++) begin
                    w = int'($urandom_range(wmin, wmax));
                    repeat (w) begin
                        c = mk(1, l, n, i, a); c.request = 1'b1; c.cv = 1'b0; tr.push_back(c);
                    end
                    c = mk(1, l, n, i, a); c.request = 1'b1; c.cv = 1'b1; c.mac_en = 1'b1;
                    tr.push_back(c);
                    a = (a + 1) % (1 << AW);
                end
                c = mk(1, l, n, 0, a); c.store_out = 1'b1; c.acc_clear = 1'b1; tr.push_back(c);
            end
            c = mk(1, l, 0, 0, a); c.swap_buf = 1'b1; tr.push_back(c);
            if (l == nl - 1) begin
                c = mk(1, l, 0, 0, a); c.done = 1'b1; tr.push_back(c);
                idle_l = l; idle_addr = a;
                break;
            end
        end
        if (abort_at > 0 && abort_at < tr.size()) begin
            c = tr[abort_at]; c.ab = 1'b1; tr[abort_at] = c;
            while (tr.size() > abort_at + 1) void'(tr.pop_back());
            idle_l = 0; idle_addr = 0;
        end
        c = mk(0, idle_l, 0, 0, idle_addr); c.start = 1'b1; tr.push_back(c);
        c = mk(0, idle_l, 0, 0, idle_addr); tr.push_back(c);
    endtask

    function automatic int find_idx(input bit want_done);
        for (int i = 0; i < tr.size(); i++) begin
            if (want_done ? tr[i].done : tr[i].error) return i;
        end
        return -1;
    endfunction

    // Apply the trace one cycle at a time, just after each rising edge
    task automatic drive_trace();
        cyc_t c;
        cyc_i = -1;
        while (tr.size() > 0) begin
            c = tr.pop_front();
            @(posedge clk);
            #1;
            start = c.start; image_loaded = c.il; coeff_valid = c.cv;
            abort = c.ab; num_layers = c.nl;
            exp_c = c;
            cyc_i++;
            m_done += int'(c.done);
            chk_en = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, s0, w0, d0, r0, md0;
        int nl, bad, ab;
        n_rst = 1'b0; start = 1'b0; image_loaded = 1'b0; abort = 1'b0;
        coeff_valid = 1'b0; num_layers = '0;
        for (int i = 0; i < 8; i++) begin rom_in[i] = 1; rom_out[i] = 1; end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_layer_idx",  32'(layer_idx),  0);
        chk("rst_neuron_idx", 32'(neuron_idx), 0);
        chk("rst_input_idx",  32'(input_idx),  0);
        chk("rst_coeff_addr", 32'(coeff_addr), 0);
        chk("rst_strobes",    32'({request, acc_clear, store_out, swap_buf, done, error}), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // 1 layer, 2 inputs, 1 neuron, coeff_valid always high
        rom_in[0] = 2; rom_out[0] = 1;
        build_run(1, 0, 0, 0);
        chk("model_t1_done_idx", 32'(find_idx(1)), 6);
        m0 = mac_cnt;
        drive_trace();
        chk("t1_done_at",      32'(done_at), 6);
        chk("t1_mac_cnt",      32'(mac_cnt - m0), 2);
        chk("t1_addr_at_done", 32'(addr_at_done), 2);

        // 2 layers (3,2) then (2,1)
        rom_in[0] = 3; rom_out[0] = 2; rom_in[1] = 2; rom_out[1] = 1;
        m0 = mac_cnt; s0 = store_cnt; w0 = swap_cnt; d0 = done_cnt;
        build_run(2, 0, 0, 0);
        drive_trace();
        chk("t2_mac_cnt",      32'(mac_cnt - m0), 8);
        chk("t2_store_cnt",    32'(store_cnt - s0), 3);
        chk("t2_swap_cnt",     32'(swap_cnt - w0), 2);
        chk("t2_done_cnt",     32'(done_cnt - d0), 1);
        chk("t2_addr_at_done", 32'(addr_at_done), 8);

        // Three idle cycles before every ack
        rom_in[0] = 2; rom_out[0] = 1;
        build_run(1, 3, 3, 0);
        chk("model_t3_done_idx", 32'(find_idx(1)), 12);
        m0 = mac_cnt; r0 = req_cnt;
        drive_trace();
        chk("t3_done_at",  32'(done_at), 12);
        chk("t3_req_cnt",  32'(req_cnt - r0), 8);
        chk("t3_mac_cnt",  32'(mac_cnt - m0), 2);

        // Illegal configurations: zero neurons, zero layers, too many inputs
        for (int k = 0; k < 3; k++) begin
            rom_in[0]  = (k == 2) ? 800 : 2;
            rom_out[0] = (k == 0) ? 0 : 1;
            s0 = store_cnt; d0 = done_cnt; w0 = swap_cnt;
            build_run((k == 1) ? 0 : 1, 0, 0, 0);
            chk("model_err_idx", 32'(find_idx(0)), 2);
            drive_trace();
            chk("err_at",        32'(error_at), 2);
            chk("err_no_store",  32'(store_cnt - s0), 0);
            chk("err_no_swap",   32'(swap_cnt - w0), 0);
            chk("err_no_done",   32'(done_cnt - d0), 0);
        end

        // Abort mid-REQ of layer 1, then a clean run
        rom_in[0] = 2; rom_out[0] = 2; rom_in[1] = 3; rom_out[1] = 1;
        d0 = done_cnt;
        build_run(2, 0, 0, 11);
        drive_trace();
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        d0 = done_cnt;
        build_run(2, 0, 1, 0);
        drive_trace();
        chk("after_abort_done", 32'(done_cnt - d0), 1);

        // Boundary sizes: maximum inputs, maximum neurons
        rom_in[0] = MI; rom_out[0] = 1; rom_in[1] = 1; rom_out[1] = MN;
        d0 = done_cnt; m0 = mac_cnt;
        build_run(2, 0, 0, 0);
        drive_trace();
        chk("max_done",    32'(done_cnt - d0), 1);
        chk("max_mac_cnt", 32'(mac_cnt - m0), MI + MN);

        // Randomized inferences
        for (int r = 0; r < 15; r++) begin
            nl = int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) begin
                rom_in[i]  = int'($urandom_range(1, 6));
                rom_out[i] = int'($urandom_range(1, 4));
            end
            bad = int'($urandom_range(0, 5));
            if (bad == 0) rom_out[$urandom_range(0, nl - 1)] = 0;
            if (bad == 1) rom_in[$urandom_range(0, nl - 1)] = 0;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            d0 = done_cnt; md0 = m_done;
            build_run(nl, 0, int'($urandom_range(0, 2)), ab);
            drive_trace();
            chk("rand_done_cnt", 32'(done_cnt - d0), 32'(m_done - md0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ann_seq_controller.md
Name: ann_seq_controller

Overview:
Parametrised multi-layer successor to the single-layer ANN controller. It sequences a fully-connected network of up to MAX_LAYERS layers over one shared MAC datapath. For each neuron it requests every coefficient from coefficient memory and strobes the MAC per coefficient. It then stores the activated result and swaps the activation buffers between layers. Layer sizes are supplied at run time by a size ROM indexed by layer_idx.

Parameters:
MAX_LAYERS, 4, maximum layers per inference
MAX_INPUTS, 784, maximum inputs per neuron
MAX_NEURONS, 64, maximum neurons per layer
ADDR_W, 16, coefficient address width
LAYER_W, $clog2(MAX_LAYERS+1), width of layer count/index
IN_W, $clog2(MAX_INPUTS+1), width of input count/index
NEU_W, $clog2(MAX_NEURONS+1), width of neuron count/index

Ports:
clk  in  1  system clock
n_rst  in  1  reset; synchronous to clk, active low
image_loaded  in  1  input image buffer full
start  in  1  begin inference
abort  in  1  synchronous abort to IDLE
num_layers  in  LAYER_W  layers this inference; sampled at start
layer_in_cnt  in  IN_W  inputs of layer layer_idx (size ROM, combinational)
layer_out_cnt  in  NEU_W  neurons of layer layer_idx (size ROM, combinational)
coeff_valid  in  1  coefficient memory ack; data valid this cycle
layer_idx  out  LAYER_W  current layer
neuron_idx  out  NEU_W  current neuron
input_idx  out  IN_W  current input (activation read address)
coeff_addr  out  ADDR_W  linear coefficient address
request  out  1  coefficient request
mac_en  out  1  accumulate one product
acc_clear  out  1  clear accumulator
store_out  out  1  write activated accumulator to neuron_idx
swap_buf  out  1  output buffer becomes next layer's input
busy  out  1  not IDLE
done  out  1  inference complete pulse
error  out  1  illegal configuration pulse

Behaviour:
- Reset (n_rst low at posedge): state IDLE. All counters and indices are 0. All strobes are 0. busy, done and error are 0.
- States are IDLE, LOAD_LAYER, REQ, STORE, LAYER_END, DONE, ERR.
- IDLE:
  - Transition to LOAD_LAYER when start && image_loaded.
  - Latch num_layers. Clear layer_idx, neuron_idx, input_idx and coeff_addr.
  - start without image_loaded is ignored. start is ignored in every non-IDLE state.
- LOAD_LAYER:
  - Sample layer_in_cnt and layer_out_cnt into registers. acc_clear=1.
  - Go to ERR if num_layers==0, if either count is 0, or if either count exceeds its MAX parameter. Otherwise go to REQ.
- REQ:
  - request=1, held until coeff_valid.
  - mac_en = coeff_valid (Mealy output, same cycle).
  - On coeff_valid: coeff_addr+1 (wraps modulo 2^ADDR_W), input_idx+1.
  - If input_idx == in_cnt-1 at that point, input_idx returns to 0 and the state goes to STORE.
  - coeff_valid outside REQ is ignored.
- STORE:
  - store_out=1 and acc_clear=1 for one cycle. neuron_idx+1.
  - If the stored neuron was the last (out_cnt-1), neuron_idx returns to 0 and the state goes to LAYER_END. Otherwise it goes to REQ.
- LAYER_END:
  - swap_buf=1 for one cycle.
  - If layer_idx == num_layers-1, go to DONE. Otherwise layer_idx+1 and go to LOAD_LAYER.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 for one cycle, then IDLE. No store_out or swap_buf is issued.
- busy=1 in every state except IDLE.
- abort, from any state: the next state is IDLE with counters cleared, as on reset, except that abort does not clear latched num_layers. abort has priority over every other transition. No done is issued.
- Latency: start is accepted in cycle T0. With coeff_valid tied high, total cycles to the done pulse = 1 + Σ_layers(1 + out_cnt·(in_cnt+1) + 1) + 1.
- Index outputs are registered. Strobes other than mac_en are state-decoded (Moore).

Decomposition:
- Package ann_pkg holds:
  - state_t enum.
  - MAX_* defaults.
  - Width localparams.
- Sub-module ann_flex_counter: a parametrised counter with clear, enable, rollover value and rollover flag. Instantiate it three times, for input, neuron and layer.
- coeff_addr is a plain register in the top module.

Test Plan:
1. Configuration: num_layers=1, in=2, out=1, coeff_valid=1, start with image_loaded.
   - Required: LOAD T1; mac_en T2–T3 with coeff_addr 0→1→2; store_out T4; swap_buf T5; done T6; busy low T7.
2. Configuration: num_layers=2, sizes (3,2) then (2,1), coeff_valid=1.
   - Required: 8 mac_en, 3 store_out, 2 swap_buf, final coeff_addr=8, one done.
3. Configuration: in=2, out=1, with coeff_valid low for 3 cycles before each ack.
   - Required: request held high throughout; mac_en only on ack cycles; done at T12.
4. Stimulus: start while image_loaded=0, then start pulsed during busy.
   - Required: no state change in either case; one done per accepted start.
5. Stimulus: layer_out_cnt=0, or num_layers=0.
   - Required: error pulse at T2, IDLE at T3, no store_out.
6. Stimulus: abort asserted mid-REQ of layer 1.
   - Required: IDLE next cycle; all indices 0; no done. A following start runs to completion normally.
